// File: rtl/mil_transmitter.sv
// mil_transmitter: MIL-STD-1553 Manchester II word transmitter.
// Serialises 16-bit words as 3+3 half-bit sync, 32 data half-bits
// and 2 parity half-bits, with a one-word holding buffer so that
// consecutive words go out back-to-back.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   enable     permits loading a new word into the shifter
//   push_req   upstream word available (type/data held while high)
//   push_type  00 command, 01 status, 1x data
//   push_data  payload, bit 15 first on the line
//   push_done  one-cycle pulse: word taken into the holding buffer
//   mil_p      line, true phase (0 when idle)
//   mil_n      line, inverted phase (0 when idle)
//   busy       buffer full or word on the line
//   request    buffer empty and enable high
module mil_transmitter #(
    parameter int HALF_BIT_CLKS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        push_req,
    input  logic [1:0]  push_type,
    input  logic [15:0] push_data,
    output logic        push_done,
    output logic        mil_p,
    output logic        mil_n,
    output logic        busy,
    output logic        request
);

    localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(HALF_BIT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PARITY
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_full;
    logic [1:0]    r_buf_type;
    logic [15:0]   r_buf_data;
    logic          r_push_done;

    logic [CW-1:0] r_clk_cnt;
    logic [4:0]    r_hb;
    logic [15:0]   r_shift;
    logic          r_sync_hi;
    logic          r_parity;

    logic          w_accept;
    logic          w_ready;
    logic          w_load;
    logic          w_hb_end;
    logic          w_state_done;
    logic          w_buf_sync_hi;
    logic          w_line;
    logic          w_active;

    assign w_accept = push_req & ~r_full;
    assign w_ready  = r_full & enable;
    assign w_hb_end = (r_clk_cnt == LAST_CLK);
    assign w_active = (r_state != S_IDLE);

    // Command and status words use the high-first sync.
    assign w_buf_sync_hi = (r_buf_type == 2'b00) | (r_buf_type == 2'b01);

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_state_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ready) begin
                    w_load = 1'b1;
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_hb_end && r_hb == 5'd5) begin
                    w_state_done = 1'b1;
                    w_next       = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hb_end && r_hb == 5'd31) begin
                    w_state_done = 1'b1;
                    w_next       = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_hb_end && r_hb == 5'd1) begin
                    w_state_done = 1'b1;
                    // Chain straight into the next word: no idle gap.
                    if (w_ready) begin
                        w_load = 1'b1;
                        w_next = S_SYNC;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Manchester: first half carries the bit, second half its inverse.
    always_comb begin
        w_line = 1'b0;
        case (r_state)
            S_SYNC:   w_line = (r_hb < 5'd3) ? r_sync_hi : ~r_sync_hi;
            S_DATA:   w_line = r_shift[15] ^ r_hb[0];
            S_PARITY: w_line = r_parity ^ r_hb[0];
            default:  w_line = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_full      <= 1'b0;
            r_buf_type  <= 2'b00;
            r_buf_data  <= 16'h0000;
            r_push_done <= 1'b0;
            r_clk_cnt   <= '0;
            r_hb        <= 5'd0;
            r_shift     <= 16'h0000;
            r_sync_hi   <= 1'b0;
            r_parity    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_push_done <= w_accept;

            // Accept needs an empty buffer and load a full one,
            // so both can never fire on the same edge.
            if (w_accept) begin
                r_full     <= 1'b1;
                r_buf_type <= push_type;
                r_buf_data <= push_data;
            end else if (w_load) begin
                r_full <= 1'b0;
            end

            if (w_load || !w_active || w_hb_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (w_load || w_state_done || !w_active) begin
                r_hb <= 5'd0;
            end else if (w_hb_end) begin
                r_hb <= r_hb + 5'd1;
            end

            if (w_load) begin
                r_shift   <= r_buf_data;
                r_sync_hi <= w_buf_sync_hi;
                r_parity  <= ~^r_buf_data;
            end else if (r_state == S_DATA && w_hb_end && r_hb[0]) begin
                r_shift <= {r_shift[14:0], 1'b0};
            end
        end
    end

    assign push_done = r_push_done;
    assign mil_p     = w_line;
    assign mil_n     = w_active & ~w_line;
    assign busy      = r_full | w_active;
    assign request   = rst & enable & ~r_full;

endmodule

// File: tb/tb_mil_transmitter.sv
// tb_mil_transmitter: scoreboard bench for mil_transmitter.
// Driver queues expected words; a line monitor decodes and compares.
module tb_mil_transmitter;

    localparam int H        = 25;
    localparam int WORD_CYC = 40 * H;

    typedef struct packed {
        logic [1:0]  t;
        logic [15:0] d;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        push_req = 1'b0;
    logic [1:0]  push_type = 2'b00;
    logic [15:0] push_data = 16'h0000;
    logic        push_done;
    logic        mil_p;
    logic        mil_n;
    logic        busy;
    logic        request;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words_done = 0;

    word_t exp_q[$];
    int    starts[$];

    mil_transmitter #(
        .HALF_BIT_CLKS(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .push_req (push_req),
        .push_type(push_type),
        .push_data(push_data),
        .push_done(push_done),
        .mil_p    (mil_p),
        .mil_n    (mil_n),
        .busy     (busy),
        .request  (request)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level for each of the 40 half-bits, MSB = first.
    function automatic logic [39:0] line_pattern(input logic [1:0] t,
                                                 input logic [15:0] d);
        logic [39:0] p;
        bit          s;
        bit          par;
        int          k;
        p   = '0;
        s   = (t == 2'b00) || (t == 2'b01);
        par = ($countones(d) % 2) == 0;
        k   = 39;
        for (int i = 0; i < 6; i++) begin
            p[k] = (i < 3) ? s : !s;
            k--;
        end
        for (int i = 15; i >= 0; i--) begin
            p[k]     = d[i];
            p[k - 1] = !d[i];
            k -= 2;
        end
        p[1] = par;
        p[0] = !par;
        return p;
    endfunction

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -1;
    endfunction

    // Line monitor
    logic [39:0] cur_pat;
    word_t       cur;
    logic        exp_bit;
    bit          in_word = 0;
    bit          orphan = 0;
    int          hidx = 0;
    int          bad = 0;
    int          first_bad = 0;

    always @(negedge clk) begin
        if (!rst) begin
            in_word = 0;
        end else begin
            if (!in_word && mil_p !== mil_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    orphan = 1;
                    $display("FAIL unexpected_word: line active at cycle %0d, required idle (no word pending)", cyc);
                end else begin
                    orphan  = 0;
                    cur     = exp_q.pop_front();
                    cur_pat = line_pattern(cur.t, cur.d);
                end
                in_word = 1;
                hidx    = 0;
                bad     = 0;
                starts.push_back(cyc);
            end
            if (in_word) begin
                exp_bit = cur_pat[39 - hidx / H];
                if (mil_p !== exp_bit || mil_n !== !exp_bit) begin
                    if (bad == 0) first_bad = hidx;
                    bad++;
                end
                hidx++;
                if (hidx == WORD_CYC) begin
                    in_word = 0;
                    words_done++;
                    if (!orphan) begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL word_pattern type %0d data %04h: %0d wrong cycles, first at offset %0d, required half-bit pattern %010h",
                                     cur.t, cur.d, bad, first_bad, cur_pat);
                        end
                    end
                end
            end else begin
                checks++;
                if (mil_p !== 1'b0 || mil_n !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_line cycle %0d: got p=%b n=%b, required p=0 n=0", cyc, mil_p, mil_n);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [1:0] t, input logic [15:0] d,
                             input int exp_wait, output int done_cyc);
        int n;
        bit got;
        exp_q.push_back(word_t'({t, d}));
        push_req  = 1'b1;
        push_type = t;
        push_data = d;
        n   = 0;
        got = 0;
        while (!got && n < 3 * WORD_CYC) begin
            tick();
            n++;
            if (push_done === 1'b1) got = 1;
        end
        push_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: no push_done after %0d cycles, required one", n);
        end else begin
            if (exp_wait > 0) check("push_latency", n, exp_wait);
            check("busy_at_push_done", busy, 1);
            check("request_at_push_done", request, 0);
        end
        done_cyc = cyc;
    endtask

    task automatic wait_idle(input int limit, output int low_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        low_cyc = cyc;
    endtask

    initial begin
        int d1, d2, d3, lo, base, wd;
        logic [1:0]  rt;
        logic [15:0] rd;

        // Reset with a pending push
        rst       = 1'b0;
        enable    = 1'b1;
        push_req  = 1'b1;
        push_data = 16'h1234;
        repeat (4) tick();
        check("rst_push_done", push_done, 0);
        check("rst_mil_p", mil_p, 0);
        check("rst_mil_n", mil_n, 0);
        check("rst_busy", busy, 0);
        check("rst_request", request, 0);
        push_req = 1'b0;
        rst      = 1'b1;
        tick();
        check("request_after_reset", request, 1);
        check("busy_after_reset", busy, 0);

        // Single command word
        base = starts.size();
        push_word(2'b00, 16'h02A1, 1, d1);
        tick();
        check("push_done_pulse", push_done, 0);
        check("request_after_load", request, 1);
        check("cmd_first_sync_p", mil_p, 1);
        check("cmd_first_sync_n", mil_n, 0);
        wait_idle(2 * WORD_CYC, lo);
        check("single_start", start_at(base), d1 + 1);
        check("single_busy_fall", lo - start_at(base), WORD_CYC);

        // Back-to-back
        base = starts.size();
        push_word(2'b00, 16'h02A1, 1, d1);
        push_word(2'b10, 16'h02A1, 2, d2);
        check("b2b_second_done", d2, d1 + 2);
        wait_idle(3 * WORD_CYC, lo);
        check("b2b_start", start_at(base), d1 + 1);
        check("b2b_gap", start_at(base + 1) - start_at(base), WORD_CYC);
        check("b2b_busy_fall", lo - start_at(base), 2 * WORD_CYC);

        // Buffer full
        base = starts.size();
        push_word(2'b01, 16'hA5C3, 1, d1);
        push_word(2'b10, 16'h0001, 2, d2);
        push_word(2'b11, 16'h8000, -1, d3);
        check("full_third_done", d3, start_at(base) + WORD_CYC + 1);
        wait_idle(4 * WORD_CYC, lo);
        check("full_busy_fall", lo - start_at(base), 3 * WORD_CYC);

        // Enable gating
        enable = 1'b0;
        base   = starts.size();
        wd     = words_done;
        push_word(2'b10, 16'hFFFF, 1, d1);
        repeat (50) tick();
        check("gate_mil_p", mil_p, 0);
        check("gate_mil_n", mil_n, 0);
        check("gate_busy", busy, 1);
        check("gate_request", request, 0);
        check("gate_no_start", starts.size(), base);
        enable = 1'b1;
        tick();
        check("data_first_sync_p", mil_p, 0);
        check("data_first_sync_n", mil_n, 1);
        repeat (200) tick();
        enable = 1'b0;
        #1;
        check("enable_low_request", request, 0);
        wait_idle(2 * WORD_CYC, lo);
        check("enable_drop_completes", words_done, wd + 1);
        check("enable_word_len", lo - start_at(base), WORD_CYC);
        enable = 1'b1;
        tick();

        // Reset mid-word
        base = starts.size();
        push_word(2'b01, 16'h5A5A, 1, d1);
        while (cyc < d1 + 1 + 20 * H) tick();
        wd  = words_done;
        rst = 1'b0;
        tick();
        check("midrst_mil_p", mil_p, 0);
        check("midrst_mil_n", mil_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_push_done", push_done, 0);
        check("midrst_request", request, 0);
        rst = 1'b1;
        repeat (WORD_CYC + 50) tick();
        check("midrst_no_more_words", starts.size(), base + 1);
        check("midrst_not_completed", words_done, wd);
        check("midrst_request_after", request, 1);

        // Randomized traffic
        wd = words_done;
        for (int i = 0; i < 15; i++) begin
            rt = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 2) repeat ($urandom_range(0, 1500)) tick();
            push_word(rt, rd, -1, d1);
        end
        wait_idle(3 * WORD_CYC, lo);
        check("random_queue_drained", exp_q.size(), 0);
        check("random_words_sent", words_done, wd + 15);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
